// File: rtl/usb_tx_pkg.sv
// Shared types and defaults for the USB transmit serializer path.
package usb_tx_pkg;
  localparam int   WORD_W_DEF     = 10;
  localparam int   STUFF_RUN_DEF  = 6;
  // Line levels shared with the word-builder stage
  localparam logic LVL_J          = 1'b1;
  localparam logic LVL_K          = 1'b0;
  localparam logic IDLE_LEVEL_DEF = LVL_J;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STUFF = 2'd2
  } state_t;
endpackage

// File: rtl/usb_nrzi_enc.sv
// Registered NRZI encoder: a 0 toggles the line, a 1 holds it.
module usb_nrzi_enc
  import usb_tx_pkg::*;
#(
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_en,
  output logic line
);
  logic r_line;

  always_ff @(posedge clk) begin
    if (!reset)                r_line <= IDLE_LEVEL;
    else if (bit_en && !bit_in) r_line <= ~r_line;
  end

  assign line = r_line;
endmodule

// File: rtl/usb_tx_serializer.sv
// LSB-first word serializer with bit stuffing after STUFF_RUN ones, NRZI line out.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int   WORD_W     = WORD_W_DEF,
  parameter int   STUFF_RUN  = STUFF_RUN_DEF,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] buff,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              busy
);
  localparam int OC_W = $clog2(STUFF_RUN + 1);
  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [OC_W-1:0] RUN_PRE  = OC_W'(STUFF_RUN - 1);

  state_t            r_state;
  logic [WORD_W-1:0] r_shreg;
  logic [BC_W-1:0]   r_bcnt;
  logic [OC_W-1:0]   r_ocnt;
  logic              r_tx_ready;
  logic              r_dout_en;

  state_t            w_state_nxt;
  logic [BC_W-1:0]   w_bcnt_nxt;
  logic [OC_W-1:0]   w_ocnt_nxt;
  logic              w_load;
  logic              w_enc_bit;
  logic              w_enc_en;
  logic              w_bit;

  assign w_bit = r_shreg[r_bcnt];

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_ocnt_nxt  = r_ocnt;
    w_load      = 1'b0;
    w_enc_bit   = 1'b1;
    w_enc_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_valid && r_tx_ready) begin
          w_load      = 1'b1;
          w_bcnt_nxt  = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_enc_en   = 1'b1;
        w_enc_bit  = w_bit;
        w_ocnt_nxt = w_bit ? r_ocnt + OC_W'(1) : '0;
        // Bit counter stays on the stuffed position; STUFF advances it
        if (w_bit && r_ocnt == RUN_PRE) w_state_nxt = ST_STUFF;
        else if (r_bcnt == LAST_BIT)    w_state_nxt = ST_IDLE;
        else                            w_bcnt_nxt  = r_bcnt + BC_W'(1);
      end
      ST_STUFF: begin
        w_enc_en   = 1'b1;
        w_enc_bit  = 1'b0;
        w_ocnt_nxt = '0;
        if (r_bcnt == LAST_BIT) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_bcnt_nxt  = r_bcnt + BC_W'(1);
          w_state_nxt = ST_SHIFT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_bcnt     <= '0;
      r_ocnt     <= '0;
      r_tx_ready <= 1'b1;
      r_dout_en  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_ocnt     <= w_ocnt_nxt;
      r_tx_ready <= (w_state_nxt == ST_IDLE);
      r_dout_en  <= w_enc_en;
      if (w_load) r_shreg <= buff;
    end
  end

  usb_nrzi_enc #(.IDLE_LEVEL(IDLE_LEVEL)) u_nrzi (
    .clk    (clk),
    .reset  (reset),
    .bit_in (w_enc_bit),
    .bit_en (w_enc_en),
    .line   (dout)
  );

  assign tx_ready = r_tx_ready;
  assign dout_en  = r_dout_en;
  assign busy     = (r_state != ST_IDLE);
endmodule

// File: tb/tb_usb_tx_serializer.sv
// Scoreboard bench: stimulus queues hand-computed line bits, a monitor pops them on dout_en.
module tb_usb_tx_serializer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] buff = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, dout, dout_en, busy;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int bitn   = 0;
  bit expq[$];

  usb_tx_serializer dut (
    .clk      (clk),
    .reset    (reset),
    .buff     (buff),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .dout     (dout),
    .dout_en  (dout_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset && tx_valid && tx_ready) hs_cnt++;

  // Monitor: every enabled line bit must match the next queued expectation
  always @(negedge clk) begin
    if (dout_en === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL extra_bit #%0d got dout=%b with dout_en=1, exp no bit", bitn, dout);
      end else begin
        bit e;
        e = expq.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL dout_bit #%0d got %b exp %b", bitn, dout, e);
        end
      end
      bitn++;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) expq.push_back(seq[i]);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    hs_cnt = 0;
  endtask

  task automatic send(input logic [9:0] w, input int exp_edges, input string nm);
    int n;
    n = 0;
    while (!tx_ready && n < 50) begin @(posedge clk); #1; n++; end
    buff = w;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk({nm, "_ready_low"}, int'(tx_ready), 0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!tx_ready && n < 50);
    chk({nm, "_ready_edges"}, n, exp_edges);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((expq.size() != 0 || busy !== 1'b0) && n < 100) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1 chk({nm, "_drained"}, expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset with tx_valid asserted: no transfer may happen
    buff = 10'h3FF;
    tx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_dout", int'(dout), 1);
    chk("rst_dout_en", int'(dout_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_no_handshake", hs_cnt, 0);
    tx_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_busy", int'(busy), 0);

    // All zeros: alternating line, no stuff
    push_seq(32'h2AA, 10);
    send(10'h000, 10, "zero");
    wait_idle("zero");

    // All ones: stuff after six ones
    do_reset();
    push_seq(32'h03F, 11);
    send(10'h3FF, 11, "ones");
    wait_idle("ones");

    // Stuff triggered by the last data bit
    do_reset();
    push_seq(32'h3FA, 11);
    send(10'h3F0, 11, "last_stuff");
    wait_idle("last_stuff");

    // Back-to-back 3FF with tx_valid held: carried count stuffs after bit 1
    do_reset();
    push_seq(32'h03F, 11);
    push_seq(32'h1FC, 12);
    buff = 10'h3FF;
    tx_valid = 1'b1;
    n = 0;
    while (hs_cnt < 2 && n < 60) begin @(posedge clk); #1; n++; end
    tx_valid = 1'b0;
    chk("xword_2nd_xfer_edge", n, 13);
    wait_idle("xword");
    repeat (5) @(posedge clk);
    #1 chk("xword_handshakes", hs_cnt, 2);

    // Reset while bit 5 of 155 is on the line
    do_reset();
    push_seq(32'h019, 6);
    buff = 10'h155;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_dout", int'(dout), 1);
    chk("midrst_dout_en", int'(dout_en), 0);
    chk("midrst_tx_ready", int'(tx_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1 chk("midrst_queue", expq.size(), 0);
    chk("midrst_busy_after", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
